// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter_checker bus monitor: FSM encoding and default sizes.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_ERR_W    = 8;
  localparam int DEF_WRAP_W   = 16;

endpackage

// File: rtl/counter_checker_if.sv
// Bundle of the monitored counter bus, control strobes and checker status outputs.
interface counter_checker_if
  import counter_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int WRAP_W = DEF_WRAP_W
);

  logic              enable;
  logic              clear_err;
  logic [WIDTH-1:0]  count_in;
  logic              locked;
  logic              error;
  logic [ERR_W-1:0]  err_count;
  logic [WIDTH-1:0]  first_bad;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output enable, clear_err, count_in,
    input  locked, error, err_count, first_bad, wrap_count
  );

  modport slave (
    input  enable, clear_err, count_in,
    output locked, error, err_count, first_bad, wrap_count
  );

endinterface

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_checker.sv
// Monitors a free-running up-counter bus: acquires lock after LOCK_CNT clean increments,
// then flags and counts any break in the +1 sequence and counts all-ones-to-zero wraps.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W,
  parameter int WRAP_W   = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              resetb,
  counter_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_valid;
  logic [3:0]        r_match;
  logic [3:0]        w_match_nxt;
  logic [WIDTH-1:0]  w_exp;
  logic              w_hit;
  logic              w_mismatch;
  logic              w_wrap;
  logic              w_locked_nxt;
  logic              r_locked;
  logic              r_error;
  logic [WIDTH-1:0]  r_first_bad;
  logic [WRAP_W-1:0] r_wrap_count;
  logic [ERR_W-1:0]  w_err_count;

  // Width-limited add makes all-ones -> 0 a legal increment.
  assign w_exp = r_prev + WIDTH'(1);
  assign w_hit = r_prev_valid && (bus.count_in == w_exp);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ACQUIRE;
        ACQUIRE: if (w_hit && ((r_match + 4'd1) == LOCK_TGT)) w_state_nxt = LOCKED;
        LOCKED:  if (!w_hit) w_state_nxt = ACQUIRE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_match_nxt = '0;
    w_mismatch  = 1'b0;
    w_wrap      = 1'b0;
    if (bus.enable) begin
      case (r_state)
        ACQUIRE: w_match_nxt = w_hit ? (r_match + 4'd1) : '0;
        LOCKED: begin
          w_mismatch = !w_hit;
          w_wrap     = w_hit && (r_prev == '1) && (bus.count_in == '0);
        end
        default: w_match_nxt = '0;
      endcase
    end
    w_locked_nxt = (w_state_nxt == LOCKED);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_match      <= '0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_first_bad  <= '0;
      r_wrap_count <= '0;
    end else begin
      if (bus.enable) r_prev <= bus.count_in;
      r_prev_valid <= bus.enable;
      r_match      <= w_match_nxt;
      r_locked     <= w_locked_nxt;
      if (w_mismatch) begin
        r_error <= 1'b1;
      end else if (bus.clear_err) begin
        r_error <= 1'b0;
      end
      // A mismatch coinciding with clear_err starts a fresh error record.
      if (w_mismatch && (!r_error || bus.clear_err)) begin
        r_first_bad <= bus.count_in;
      end else if (bus.clear_err) begin
        r_first_bad <= '0;
      end
      if (w_wrap) r_wrap_count <= r_wrap_count + WRAP_W'(1);
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (resetb),
    .i_clr   (bus.clear_err),
    .i_inc   (w_mismatch),
    .o_count (w_err_count)
  );

  assign bus.locked     = r_locked;
  assign bus.error      = r_error;
  assign bus.err_count  = w_err_count;
  assign bus.first_bad  = r_first_bad;
  assign bus.wrap_count = r_wrap_count;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receiving-end monitor for an 8-bit free-running up-counter bus such as `result`.
- Samples the bus every clock and confirms each value is the previous value plus one, modulo 2^WIDTH.
- Reports lock status, a sticky error flag, a saturating error count, the first offending value and a wrap-around count.
- Sits beside counter benchmarks on the FPGA fabric as a self-check: one clock, no handshake with the producer.

Parameters:
- WIDTH, 8, width of the monitored counter bus.
- LOCK_CNT, 4, consecutive correct increments required to declare lock (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 16, width of the wrap counter, which rolls over modulo 2^WRAP_W.

Ports:
- clk  input  1  sampling clock, the same clock as the counter producer.
- resetb  input  1  asynchronous, active-low reset.
- enable  input  1  check enable; while low the block idles.
- clear_err  input  1  synchronous clear of the error reporting state.
- count_in  input  WIDTH  counter value under test.
- locked  output  1  registered; high while in state LOCKED.
- error  output  1  registered; sticky mismatch flag.
- err_count  output  ERR_W  registered; mismatches seen while locked, saturating at all-ones.
- first_bad  output  WIDTH  registered; count_in value of the first mismatch since reset or clear.
- wrap_count  output  WRAP_W  registered; observed all-ones-to-zero transitions while locked.

Behaviour:
- Reset (resetb low, asynchronous): state=IDLE, prev=0, prev_valid=0, match=0; locked=0, error=0, err_count=0, first_bad=0, wrap_count=0.
- Sampling: count_in is sampled on every posedge clk. All outputs are registered and reflect the sample taken on the same edge.
- Expected value: exp = (prev + 1) mod 2^WIDTH.
  - The comparison is made at WIDTH bits, so all-ones followed by 0 is a correct increment.
- prev update: prev is loaded with count_in on every edge while enable=1. prev_valid is set on the first such edge.
- State IDLE:
  - locked=0 and match=0.
  - enable=1 → ACQUIRE, with prev loaded from count_in and prev_valid=1.
- State ACQUIRE:
  - Sample with prev_valid=1 and count_in==exp → match++.
  - Sample with count_in!=exp → match=0. This is not counted as an error.
  - When the increment makes match equal LOCK_CNT → LOCKED. With a clean stream, locked rises on the edge of sample LOCK_CNT+1 after entering ACQUIRE.
- State LOCKED:
  - count_in==exp → stay in LOCKED. If prev is all-ones and count_in is 0, wrap_count++ (wrapping).
  - count_in!=exp → error=1, err_count++ unless already saturated, match=0, go to ACQUIRE, locked=0 on that same edge.
  - If error was 0 before this edge, first_bad ← count_in.
  - A producer reset to 0 mid-count is a mismatch unless prev was all-ones.
- enable low in any state → IDLE on the next edge, with prev_valid=0.
  - error, err_count, first_bad and wrap_count hold their values.
- clear_err=1:
  - Clears error, err_count and first_bad on that edge.
  - If a mismatch is detected on the same edge, the mismatch wins: error=1, err_count=1, first_bad=count_in.
  - clear_err does not affect state, locked or wrap_count.
- resetb asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - The state encoding: IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - Default constants for LOCK_CNT, ERR_W and WRAP_W.
- One sub-module, sat_counter, is natural: a parameterised-width saturating incrementer with synchronous clear.
  - It is instantiated for err_count.
  - wrap_count uses a plain wrapping increment.

Test Plan:
- Reset, then enable=1 with count_in=0,1,2,… → locked=0 through sample 4 and locked=1 on the 5th edge (LOCK_CNT=4); error=0.
- Locked, then count_in 0xFE,0xFF,0x00,0x01 → wrap_count increments from 0 to 1 on the 0x00 edge; error stays 0; locked stays 1.
- Locked at 0x10, then inject 0x33 → on that edge error=1, err_count=1, first_bad=0x33, locked=0; after 4 further clean increments (0x34..0x37) locked=1 again.
- Force 300 mismatches while locked, each followed by a relock → err_count saturates at 0xFF; first_bad keeps its first value.
- Mismatch and clear_err=1 on the same edge → error=1, err_count=1, first_bad=the new value. A clear_err pulse alone → error=0, err_count=0, first_bad=0x00.
- Assert resetb low between edges while locked with err_count=3 → all outputs 0 immediately. Drop enable while locked → locked=0 on the next edge, err_count is retained, and a re-enable requires a fresh lock.
